// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI register-write link (controller and peripheral).
package spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam logic        WRITE_BIT  = 1'b1;

    localparam int unsigned RW_POS   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    typedef logic [1:0]            spi_state_t;
    typedef logic [FRAME_BITS-1:0] spi_frame_t;

    localparam spi_state_t StIdle  = 2'd0;
    localparam spi_state_t StSetup = 2'd1;
    localparam spi_state_t StShift = 2'd2;
    localparam spi_state_t StGap   = 2'd3;

    function automatic spi_frame_t spi_build_frame(input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
        spi_frame_t f;
        f                    = '0;
        f[RW_POS]            = WRITE_BIT;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider: strobes the end of each low phase (rise) and high phase (fall).
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic            wrap;

    // phase_q = 0 while the current half-period is the low one.
    always_comb begin
        wrap    = en_i && (cnt_q == CntMax);
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en_i) begin
            cnt_d   = wrap ? '0 : cnt_q + 1'b1;
            phase_d = wrap ? ~phase_q : phase_q;
        end
        rise_o = wrap && !phase_q;
        fall_o = wrap && phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: one {addr,data} frame per valid/ready handshake, MSB first.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              copi,
    output logic              ncs
);

    localparam int unsigned     GapW    = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;
    localparam logic [GapW-1:0] GapLoad = GapW'(CS_GAP - 1);

    spi_state_t      state_q, state_d;
    spi_frame_t      shift_q, shift_d;
    logic [4:0]      bit_q, bit_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            sclk_q, sclk_d;
    logic            copi_q, copi_d;
    logic            ncs_q, ncs_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            div_en, rise, fall;
    spi_frame_t      frame;

    assign div_en = (state_q == StSetup) || (state_q == StShift);
    assign frame  = spi_build_frame(tx_addr, tx_data);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (div_en),
        .rise_o(rise),
        .fall_o(fall)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // ready_q is low for the first cycle after reset release.
                if (tx_valid && ready_q) begin
                    state_d = StSetup;
                    shift_d = frame;
                    copi_d  = frame[FRAME_BITS-1];
                    bit_d   = 5'd15;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                end
            end
            StSetup: begin
                if (rise) begin
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (fall) begin
                    sclk_d  = 1'b0;
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    copi_d  = shift_q[FRAME_BITS-2];
                end else if (rise) begin
                    // bit_q names the bit being clocked; at 0 this rise slot closes the frame.
                    if (bit_q == 5'd0) begin
                        state_d = StGap;
                        ncs_d   = 1'b1;
                        copi_d  = 1'b0;
                        done_d  = 1'b1;
                        gap_d   = GapLoad;
                    end else begin
                        bit_d  = bit_q - 5'd1;
                        sclk_d = 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sclk     = sclk_q;
    assign copi     = copi_q;
    assign ncs      = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: two controllers (CLK_DIV=4/CS_GAP=4 and CLK_DIV=7/CS_GAP=1) observed by a bus monitor.
module tb_spi_controller;

    logic       clk;
    logic       rst_n    [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic [6:0] tx_addr  [2];
    logic [7:0] tx_data  [2];
    logic       busy     [2];
    logic       done     [2];
    logic       sclk     [2];
    logic       copi     [2];
    logic       ncs      [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_controller #(
        .CLK_DIV(4),
        .CS_GAP (4)
    ) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n[0]),
        .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]),
        .tx_addr (tx_addr[0]),
        .tx_data (tx_data[0]),
        .busy    (busy[0]),
        .done    (done[0]),
        .sclk    (sclk[0]),
        .copi    (copi[0]),
        .ncs     (ncs[0])
    );

    spi_controller #(
        .CLK_DIV(7),
        .CS_GAP (1)
    ) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n[1]),
        .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]),
        .tx_addr (tx_addr[1]),
        .tx_data (tx_data[1]),
        .busy    (busy[1]),
        .done    (done[1]),
        .sclk    (sclk[1]),
        .copi    (copi[1]),
        .ncs     (ncs[1])
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor state, one slot per DUT; logs indexed by frame / accept number.
    int unsigned cyc            = 0;
    int unsigned frame_cnt  [2] = '{0, 0};
    int unsigned done_cnt   [2] = '{0, 0};
    int unsigned acc_cnt    [2] = '{0, 0};
    int unsigned cur_rises  [2] = '{0, 0};
    int unsigned cur_low    [2] = '{0, 0};
    int unsigned run_len    [2] = '{0, 0};
    int unsigned high_run   [2] = '{0, 0};
    int unsigned hi_min     [2] = '{0, 0};
    int unsigned hi_max     [2] = '{0, 0};
    int unsigned lo_min     [2] = '{0, 0};
    int unsigned lo_max     [2] = '{0, 0};
    int unsigned last_low   [2] = '{0, 0};
    int unsigned last_rises [2] = '{0, 0};
    logic [15:0] cur_shreg  [2] = '{16'h0, 16'h0};
    logic        prev_sclk  [2] = '{1'b0, 1'b0};
    logic        prev_ncs   [2] = '{1'b1, 1'b1};
    logic [15:0] f_log      [2][64];
    int unsigned gap_log    [2][64];
    int unsigned acc_log    [2][64];

    task automatic rec_run(input int k, input logic lvl, input int unsigned len);
        if (lvl) begin
            if (len < hi_min[k]) hi_min[k] = len;
            if (len > hi_max[k]) hi_max[k] = len;
        end else begin
            if (len < lo_min[k]) lo_min[k] = len;
            if (len > lo_max[k]) lo_max[k] = len;
        end
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (!ncs[k]) begin
                if (prev_ncs[k]) begin
                    gap_log[k][frame_cnt[k] % 64] = high_run[k];
                    cur_low[k]   = 1;
                    cur_rises[k] = 0;
                    cur_shreg[k] = 16'h0;
                    run_len[k]   = 1;
                    hi_min[k]    = 999;
                    hi_max[k]    = 0;
                    lo_min[k]    = 999;
                    lo_max[k]    = 0;
                end else begin
                    cur_low[k]++;
                    if (sclk[k] == prev_sclk[k]) begin
                        run_len[k]++;
                    end else begin
                        rec_run(k, prev_sclk[k], run_len[k]);
                        run_len[k] = 1;
                        if (sclk[k]) begin
                            cur_rises[k]++;
                            cur_shreg[k] = {cur_shreg[k][14:0], copi[k]};
                        end
                    end
                end
            end else begin
                if (!prev_ncs[k]) begin
                    rec_run(k, prev_sclk[k], run_len[k]);
                    f_log[k][frame_cnt[k] % 64] = cur_shreg[k];
                    last_low[k]   = cur_low[k];
                    last_rises[k] = cur_rises[k];
                    frame_cnt[k]++;
                    high_run[k] = 1;
                end else begin
                    high_run[k]++;
                end
            end
            if (done[k]) done_cnt[k]++;
            if (tx_valid[k] && tx_ready[k]) begin
                acc_log[k][acc_cnt[k] % 64] = cyc;
                acc_cnt[k]++;
            end
            prev_ncs[k]  = ncs[k];
            prev_sclk[k] = sclk[k];
        end
    end

    task automatic wait_ready(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (tx_ready[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("ready_timeout", 32'(tx_ready[k]), 32'd1);
    endtask

    // Leaves tx_data at d_after from the cycle after the accept edge.
    task automatic send(input int k, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] d_after);
        wait_ready(k);
        tx_valid[k] = 1'b1;
        tx_addr[k]  = a;
        tx_data[k]  = d;
        @(posedge clk);
        #1;
        tx_valid[k] = 1'b0;
        tx_data[k]  = d_after;
    endtask

    task automatic wait_frames(input int k, input int unsigned target);
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            if (frame_cnt[k] >= target) break;
        end
        if (frame_cnt[k] < target) check_eq("frame_timeout", frame_cnt[k], target);
    endtask

    task automatic wait_acc(input int k, input int unsigned target);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (acc_cnt[k] >= target) break;
        end
        if (acc_cnt[k] < target) check_eq("accept_timeout", acc_cnt[k], target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned fstart, astart, dstart;
        bit          seen;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]    = 1'b0;
            tx_valid[k] = 1'b0;
            tx_addr[k]  = 7'h0;
            tx_data[k]  = 8'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ncs", 32'(ncs[0]), 32'd1);
        check_eq("rst_sclk", 32'(sclk[0]), 32'd0);
        check_eq("rst_copi", 32'(copi[0]), 32'd0);
        check_eq("rst_ready", 32'(tx_ready[0]), 32'd0);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        check_eq("rst_done", 32'(done[0]), 32'd0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        check_eq("ready_before_first_clk", 32'(tx_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        check_eq("ready_after_release", 32'(tx_ready[0]), 32'd1);

        // Single frame 0x81A5
        dstart = done_cnt[0];
        send(0, 7'h01, 8'hA5, 8'hA5);
        check_eq("t1_busy", 32'(busy[0]), 32'd1);
        check_eq("t1_ncs_low", 32'(ncs[0]), 32'd0);
        check_eq("t1_copi_msb", 32'(copi[0]), 32'd1);
        check_eq("t1_sclk_low", 32'(sclk[0]), 32'd0);
        wait_frames(0, 1);
        check_eq("t1_frame", 32'(f_log[0][0]), 32'h81A5);
        check_eq("t1_ncs_low_len", last_low[0], 32'd132);
        check_eq("t1_rises", last_rises[0], 32'd16);
        check_eq("t1_done_pulses", done_cnt[0] - dstart, 32'd1);

        // Back-to-back with tx_valid held
        fstart = frame_cnt[0];
        astart = acc_cnt[0];
        wait_ready(0);
        tx_valid[0] = 1'b1;
        tx_addr[0]  = 7'h00;
        tx_data[0]  = 8'h00;
        wait_acc(0, astart + 1);
        #1;
        tx_data[0] = 8'hFF;
        wait_acc(0, astart + 2);
        #1;
        tx_data[0] = 8'h3C;
        wait_acc(0, astart + 3);
        #1;
        tx_valid[0] = 1'b0;
        wait_frames(0, fstart + 3);
        check_eq("t2_period1", acc_log[0][astart+1] - acc_log[0][astart], 32'd137);
        check_eq("t2_period2", acc_log[0][astart+2] - acc_log[0][astart+1], 32'd137);
        check_eq("t2_frame0", 32'(f_log[0][fstart]), 32'h8000);
        check_eq("t2_frame1", 32'(f_log[0][fstart+1]), 32'h80FF);
        check_eq("t2_frame2", 32'(f_log[0][fstart+2]), 32'h803C);
        check_eq("t2_gap1", gap_log[0][fstart+1], 32'd5);
        check_eq("t2_gap2", gap_log[0][fstart+2], 32'd5);

        // tx_valid pulsed during SHIFT and GAP
        fstart = frame_cnt[0];
        astart = acc_cnt[0];
        send(0, 7'h05, 8'h12, 8'h12);
        repeat (20) @(posedge clk);
        #1;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hEE;
        check_eq("t3_ready_in_shift", 32'(tx_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        wait_frames(0, fstart + 1);
        #1;
        tx_valid[0] = 1'b1;
        check_eq("t3_ready_in_gap", 32'(tx_ready[0]), 32'd0);
        check_eq("t3_busy_in_gap", 32'(busy[0]), 32'd1);
        check_eq("t3_ncs_in_gap", 32'(ncs[0]), 32'd1);
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        repeat (40) @(posedge clk);
        check_eq("t3_accepts", acc_cnt[0] - astart, 32'd1);
        check_eq("t3_no_extra_frame", frame_cnt[0], fstart + 1);
        check_eq("t3_frame", 32'(f_log[0][fstart]), 32'h8512);

        // tx_data changes right after accept
        fstart = frame_cnt[0];
        send(0, 7'h22, 8'h5A, 8'h00);
        wait_frames(0, fstart + 1);
        check_eq("t4_frame", 32'(f_log[0][fstart]), 32'hA25A);

        // Reset during bit 9 (frame 0xB3C3)
        fstart = frame_cnt[0];
        dstart = done_cnt[0];
        send(0, 7'h33, 8'hC3, 8'hC3);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (cur_rises[0] == 7) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq("t5_bit9_timeout", cur_rises[0], 32'd7);
        @(posedge clk);
        #1;
        check_eq("t5_sclk_before_rst", 32'(sclk[0]), 32'd1);
        check_eq("t5_copi_bit9", 32'(copi[0]), 32'd1);
        rst_n[0] = 1'b0;
        #1;
        check_eq("t5_rst_ncs", 32'(ncs[0]), 32'd1);
        check_eq("t5_rst_sclk", 32'(sclk[0]), 32'd0);
        check_eq("t5_rst_copi", 32'(copi[0]), 32'd0);
        check_eq("t5_rst_busy", 32'(busy[0]), 32'd0);
        repeat (3) @(posedge clk);
        check_eq("t5_no_done_on_abort", done_cnt[0] - dstart, 32'd0);
        #1;
        rst_n[0] = 1'b1;
        send(0, 7'h10, 8'h99, 8'h99);
        wait_frames(0, fstart + 2);
        check_eq("t5_next_frame", 32'(f_log[0][fstart+1]), 32'h9099);
        check_eq("t5_next_low_len", last_low[0], 32'd132);
        check_eq("t5_next_rises", last_rises[0], 32'd16);
        check_eq("t5_done_after", done_cnt[0] - dstart, 32'd1);

        // CLK_DIV=7, CS_GAP=1 instance
        fstart = frame_cnt[1];
        send(1, 7'h7F, 8'h01, 8'h01);
        wait_frames(1, fstart + 1);
        check_eq("t6_frame", 32'(f_log[1][fstart]), 32'hFF01);
        check_eq("t6_ncs_low_len", last_low[1], 32'd231);
        check_eq("t6_rises", last_rises[1], 32'd16);
        check_eq("t6_high_min", hi_min[1], 32'd7);
        check_eq("t6_high_max", hi_max[1], 32'd7);
        check_eq("t6_low_min", lo_min[1], 32'd7);
        check_eq("t6_low_max", lo_max[1], 32'd7);
        check_eq("t6_done_pulses", done_cnt[1], 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
